intsat_pipe: RTL and testbench

- Pipelined, parametrised successor to the combinational integer saturator in the control loop.
- Narrows a signed IN_LEN-bit accumulator to OUT_LEN = IN_LEN-LTRUNC bits.
- Applies a runtime arithmetic right shift (gain scaling) first, then clamps to the output range.
- Uses valid/ready handshakes on both sides, per-sample saturation flags, and a sticky saturation event counter for software monitoring.

---
 rtl/intsat_pipe.sv | 140 ++++++++++++++
 tb/tb_intsat_pipe.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/intsat_pipe.sv
// intsat_pipe: two-stage signed shift-and-saturate with valid/ready handshakes.
// Optional round-half-up before the shift: define INTSAT_PIPE_ROUND_EN.
module intsat_pipe #(
    parameter int IN_LEN     = 64,
    parameter int LTRUNC     = 32,
    parameter int SHIFT_WID  = 6,
    parameter int SATCNT_WID = 16
) (
    input  logic                             clk,
    input  logic                             rst_L,
    input  logic [SHIFT_WID-1:0]             shift,
    input  logic signed [IN_LEN-1:0]         inp,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic signed [IN_LEN-LTRUNC-1:0]  outp,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             sat_hi,
    output logic                             sat_lo,
    output logic [SATCNT_WID-1:0]            sat_cnt,
    input  logic                             clr_cnt
);

    localparam int OUT_LEN = IN_LEN - LTRUNC;
    localparam int W1      = IN_LEN + 1;

    localparam logic signed [W1-1:0] MAXV =
        {{(LTRUNC+2){1'b0}}, {(OUT_LEN-1){1'b1}}};
    localparam logic signed [W1-1:0] MINV =
        {{(LTRUNC+2){1'b1}}, {(OUT_LEN-1){1'b0}}};
    localparam logic [OUT_LEN-1:0] OMAX = {1'b0, {(OUT_LEN-1){1'b1}}};
    localparam logic [OUT_LEN-1:0] OMIN = {1'b1, {(OUT_LEN-1){1'b0}}};

    logic                    r_s1_valid;
    logic signed [W1-1:0]    r_s1_val;
    logic                    r_s2_valid;
    logic [OUT_LEN-1:0]      r_outp;
    logic                    r_sat_hi;
    logic                    r_sat_lo;
    logic [SATCNT_WID-1:0]   r_cnt;

    logic                    w_s2_ld;
    logic                    w_s1_ld;
    logic                    w_in_xfer;
    logic                    w_out_xfer;
    logic [31:0]             w_shamt;
    logic [31:0]             w_shc;
    logic signed [W1-1:0]    w_ext;
    logic signed [W1-1:0]    w_sum;
    logic signed [W1-1:0]    w_s1_d;
    logic                    w_hi;
    logic                    w_lo;
    logic [OUT_LEN-1:0]      w_sat;

    // A stage loads when empty or when its content leaves this cycle.
    assign w_s2_ld    = !r_s2_valid || out_ready;
    assign w_s1_ld    = !r_s1_valid || w_s2_ld;
    assign in_ready   = w_s1_ld;
    assign w_in_xfer  = in_valid && w_s1_ld;
    assign w_out_xfer = r_s2_valid && out_ready;

    // Shifts past the sign bit all give 0 or -1, so clamp the amount.
    assign w_shamt = 32'(shift);
    assign w_shc   = (w_shamt > 32'(IN_LEN)) ? 32'(IN_LEN) : w_shamt;
    assign w_ext   = {inp[IN_LEN-1], inp};

`ifdef INTSAT_PIPE_ROUND_EN
    logic [W1-1:0] w_rnd;
    // Half-LSB bias in the extra top bit cannot overflow.
    assign w_rnd = (w_shamt != 32'd0 && w_shamt <= 32'(IN_LEN))
                 ? ({{(W1-1){1'b0}}, 1'b1} << (w_shamt - 32'd1))
                 : '0;
    assign w_sum = w_ext + $signed(w_rnd);
`else
    assign w_sum = w_ext;
`endif

    assign w_s1_d = w_sum >>> w_shc;

    // S1: capture the scaled sample on each accepted input.
    always_ff @(posedge clk) begin
        if (!rst_L) begin
            r_s1_valid <= 1'b0;
            r_s1_val   <= '0;
        end else if (w_s1_ld) begin
            r_s1_valid <= in_valid;
            if (w_in_xfer) begin
                r_s1_val <= w_s1_d;
            end
        end
    end

    assign w_hi = (r_s1_val > MAXV);
    assign w_lo = (r_s1_val < MINV);

    // Clamp the scaled value into the narrow output range.
    always_comb begin
        w_sat = r_s1_val[OUT_LEN-1:0];
        if (w_hi) begin
            w_sat = OMAX;
        end else if (w_lo) begin
            w_sat = OMIN;
        end
    end

    // S2: output register, held while downstream stalls.
    always_ff @(posedge clk) begin
        if (!rst_L) begin
            r_s2_valid <= 1'b0;
            r_outp     <= '0;
            r_sat_hi   <= 1'b0;
            r_sat_lo   <= 1'b0;
        end else if (w_s2_ld) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_outp   <= w_sat;
                r_sat_hi <= w_hi;
                r_sat_lo <= w_lo;
            end
        end
    end

    // Sticky event counter; clear has priority over a count.
    always_ff @(posedge clk) begin
        if (!rst_L) begin
            r_cnt <= '0;
        end else if (clr_cnt) begin
            r_cnt <= '0;
        end else if (w_out_xfer && (r_sat_hi || r_sat_lo) && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign outp      = r_outp;
    assign out_valid = r_s2_valid;
    assign sat_hi    = r_sat_hi;
    assign sat_lo    = r_sat_lo;
    assign sat_cnt   = r_cnt;

endmodule

// File: tb/tb_intsat_pipe.sv
// tb_intsat_pipe: table vectors, hand sequences and random traffic
// against a scoreboard fed by a wide-integer reference model.
module tb_intsat_pipe;

`ifdef INTSAT_PIPE_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    typedef struct {
        logic [31:0] outp;
        logic        hi;
        logic        lo;
        int          cyc;
        logic        lat;
    } exp_t;

    typedef struct {
        logic [63:0] inp;
        logic [5:0]  sh;
        logic [31:0] outp;
        logic        hi;
        logic        lo;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_L;
    logic [5:0]  shift;
    logic [63:0] inp;
    logic        in_valid;
    logic        in_ready, in_ready2;
    logic [31:0] outp, outp2;
    logic        out_valid, out_valid2;
    logic        out_ready;
    logic        sat_hi, sat_lo, sat_hi2, sat_lo2;
    logic [15:0] sat_cnt;
    logic [1:0]  sat_cnt2;
    logic        clr_cnt;

    int          n_vec = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          m_cnt = 0;
    int          m_cnt2 = 0;
    exp_t        sbq[$];
    vec_t        tbl[$];

    always #5 clk = ~clk;

    intsat_pipe #(.IN_LEN(64), .LTRUNC(32), .SHIFT_WID(6), .SATCNT_WID(16)) u_dut (
        .clk(clk), .rst_L(rst_L), .shift(shift), .inp(inp),
        .in_valid(in_valid), .in_ready(in_ready), .outp(outp),
        .out_valid(out_valid), .out_ready(out_ready), .sat_hi(sat_hi),
        .sat_lo(sat_lo), .sat_cnt(sat_cnt), .clr_cnt(clr_cnt)
    );

    intsat_pipe #(.IN_LEN(64), .LTRUNC(32), .SHIFT_WID(6), .SATCNT_WID(2)) u_dut2 (
        .clk(clk), .rst_L(rst_L), .shift(shift), .inp(inp),
        .in_valid(in_valid), .in_ready(in_ready2), .outp(outp2),
        .out_valid(out_valid2), .out_ready(out_ready), .sat_hi(sat_hi2),
        .sat_lo(sat_lo2), .sat_cnt(sat_cnt2), .clr_cnt(clr_cnt)
    );

    // Reference: exact integer math, floor division by 2^sh, then clamp.
    function automatic exp_t model(input logic [63:0] x, input logic [5:0] sh);
        logic signed [127:0] v;
        exp_t e;
        v = {{64{x[63]}}, x};
        if (RND && sh != 6'd0) v = v + (128'sd1 <<< (sh - 6'd1));
        v = v >>> sh;
        e.hi = 1'b0; e.lo = 1'b0; e.cyc = 0; e.lat = 1'b0;
        if (v > 128'sd2147483647) begin
            e.outp = 32'h7fffffff; e.hi = 1'b1;
        end else if (v < -128'sd2147483648) begin
            e.outp = 32'h80000000; e.lo = 1'b1;
        end else begin
            e.outp = v[31:0];
        end
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] x);
        n_vec++;
        if (a !== x) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", nm, a, x, cyc);
        end
    endtask

    task automatic drive(input logic v, input logic [63:0] d, input logic [5:0] sh,
                         input logic ordy, input logic clr, input exp_t e_in,
                         output logic acc);
        exp_t f;
        logic ox;
        @(negedge clk);
        in_valid = v; inp = d; shift = sh; out_ready = ordy; clr_cnt = clr;
        #1;
        chk("sat_cnt", 64'(sat_cnt), 64'(m_cnt));
        chk("sat_cnt2", 64'(sat_cnt2), 64'(m_cnt2));
        ox = 1'b0;
        f = e_in;
        if (out_valid) begin
            if (sbq.size() == 0) begin
                n_vec++; n_bad++;
                $display("FAIL spurious: out_valid with nothing pending, outp=0x%0h", outp);
            end else begin
                f = sbq[0];
                chk("outp", 64'(outp), 64'(f.outp));
                chk("sat_hi", 64'(sat_hi), 64'(f.hi));
                chk("sat_lo", 64'(sat_lo), 64'(f.lo));
                chk("outp2", 64'(outp2), 64'(f.outp));
                chk("flags2", 64'({sat_hi2, sat_lo2}), 64'({f.hi, f.lo}));
                chk("valid2", 64'(out_valid2), 64'd1);
                if (ordy) begin
                    ox = 1'b1;
                    if (f.lat) chk("latency", 64'(cyc - f.cyc), 64'd2);
                    void'(sbq.pop_front());
                end
            end
        end
        if (clr) begin
            m_cnt = 0; m_cnt2 = 0;
        end else if (ox && (f.hi || f.lo)) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
        end
        acc = v && in_ready;
        if (acc) begin
            f = e_in; f.cyc = cyc; sbq.push_back(f);
        end
        cyc++;
    endtask

    task automatic idle(input int n, input logic ordy);
        exp_t z;
        logic a;
        z = '{outp: 32'd0, hi: 1'b0, lo: 1'b0, cyc: 0, lat: 1'b0};
        for (int i = 0; i < n; i++) drive(1'b0, 64'd0, 6'd0, ordy, 1'b0, z, a);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst_L = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clr_cnt = 1'b0;
        repeat (n) @(negedge clk);
        rst_L = 1'b1;
        sbq.delete();
        m_cnt = 0; m_cnt2 = 0;
        #1;
    endtask

    task automatic add(input logic [63:0] x, input logic [5:0] sh, input logic [31:0] o,
                       input logic hi, input logic lo);
        vec_t t;
        t.inp = x; t.sh = sh; t.outp = o; t.hi = hi; t.lo = lo;
        tbl.push_back(t);
    endtask

    initial begin
        exp_t e;
        logic acc, v, ordy, clr;
        logic [63:0] d;
        logic [5:0] sh;
        int nxt;

        rst_L = 1'b0; in_valid = 1'b0; inp = '0; shift = '0;
        out_ready = 1'b0; clr_cnt = 1'b0;
        do_reset(2);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_outp", 64'(outp), 64'd0);
        chk("rst_flags", 64'({sat_hi, sat_lo}), 64'd0);
        chk("rst_sat_cnt", 64'(sat_cnt), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        for (int i = 0; i < 7; i++)
            add(64'(410000000 + i), 6'd0, 32'(410000000 + i), 1'b0, 1'b0);
        add(64'sd3000000000, 6'd0, 32'h7fffffff, 1'b1, 1'b0);
        add(-64'sd3000000000, 6'd0, 32'h80000000, 1'b0, 1'b1);
        add(-64'sd1000000000, 6'd0, 32'hc4653600, 1'b0, 1'b0);
        add(64'sd100, 6'd4, 32'd6, 1'b0, 1'b0);
        add(-64'sd24, 6'd4, RND ? 32'hffffffff : 32'hfffffffe, 1'b0, 1'b0);
        add(-64'sd5, 6'd63, RND ? 32'd0 : 32'hffffffff, 1'b0, 1'b0);
        add(64'h7fffffffffffffff, 6'd63, RND ? 32'd1 : 32'd0, 1'b0, 1'b0);
        add(64'sd7, 6'd1, RND ? 32'd4 : 32'd3, 1'b0, 1'b0);
        add(-64'sd7, 6'd1, RND ? 32'hfffffffd : 32'hfffffffc, 1'b0, 1'b0);
        add(64'sd2147483647, 6'd0, 32'h7fffffff, 1'b0, 1'b0);
        add(64'sd2147483648, 6'd0, 32'h7fffffff, 1'b1, 1'b0);
        add(-64'sd2147483648, 6'd0, 32'h80000000, 1'b0, 1'b0);
        add(-64'sd2147483649, 6'd0, 32'h80000000, 1'b0, 1'b1);
        add(64'h0000010000000000, 6'd8, 32'h7fffffff, 1'b1, 1'b0);
        add(64'hffffffffffffffff, 6'd0, 32'hffffffff, 1'b0, 1'b0);

        foreach (tbl[i]) begin
            e.outp = tbl[i].outp; e.hi = tbl[i].hi; e.lo = tbl[i].lo;
            e.cyc = 0; e.lat = 1'b1;
            drive(1'b1, tbl[i].inp, tbl[i].sh, 1'b1, 1'b0, e, acc);
            chk("tbl_accept", 64'(acc), 64'd1);
        end
        idle(4, 1'b1);
        chk("tbl_sat_cnt", 64'(sat_cnt), 64'd5);
        chk("tbl_sat_cnt_sticky", 64'(sat_cnt2), 64'd3);

        nxt = 1;
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, 64'(nxt), 6'd0, 1'b0, 1'b0, model(64'(nxt), 6'd0), acc);
            chk("bp_in_ready", 64'(in_ready), (c < 2) ? 64'd1 : 64'd0);
            chk("bp_in_ready2", 64'(in_ready2), (c < 2) ? 64'd1 : 64'd0);
            if (acc) nxt++;
        end
        for (int k = 0; k < 12 && nxt <= 4; k++) begin
            drive(1'b1, 64'(nxt), 6'd0, 1'b1, 1'b0, model(64'(nxt), 6'd0), acc);
            if (acc) nxt++;
        end
        chk("bp_all_accepted", 64'(nxt), 64'd5);
        idle(4, 1'b1);
        chk("bp_drained", 64'(sbq.size()), 64'd0);

        drive(1'b1, 64'sd3000000000, 6'd0, 1'b0, 1'b0,
              model(64'sd3000000000, 6'd0), acc);
        idle(2, 1'b0);
        drive(1'b0, 64'd0, 6'd0, 1'b1, 1'b1, model(64'd0, 6'd0), acc);
        idle(1, 1'b1);
        chk("clr_wins", 64'(sat_cnt), 64'd0);

        drive(1'b1, 64'sd3000000000, 6'd0, 1'b1, 1'b0,
              model(64'sd3000000000, 6'd0), acc);
        drive(1'b1, -64'sd3000000000, 6'd0, 1'b1, 1'b0,
              model(-64'sd3000000000, 6'd0), acc);
        do_reset(1);
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_sat_cnt", 64'(sat_cnt), 64'd0);
        idle(5, 1'b1);

        for (int i = 0; i < 400; i++) begin
            v    = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            clr  = ($urandom_range(0, 49) == 0);
            sh   = ($urandom_range(0, 2) == 0) ? 6'd0 : 6'($urandom_range(0, 63));
            case ($urandom_range(0, 2))
                0: d = {{32{1'b0}}, 32'($urandom)} - 64'h0000000080000000;
                1: d = {32'($urandom), 32'($urandom)};
                default: d = ($urandom_range(0, 1) ? 64'sd2147483647 : -64'sd2147483648)
                             + 64'($urandom_range(0, 4)) - 64'd2;
            endcase
            drive(v, d, sh, ordy, clr, model(d, sh), acc);
        end
        for (int k = 0; k < 20 && sbq.size() > 0; k++) idle(1, 1'b1);
        if (sbq.size() != 0) begin
            n_vec++; n_bad++;
            $display("FAIL drain_timeout: %0d samples never emitted, want 0", sbq.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
